// File: rtl/ram_arb_pkg.sv
// Shared constants for the RAM read-port arbiter: requester IDs, default widths
// and the stall counter ceiling.
package ram_arb_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 8;

  // Owner of the read issued on the previous clock.
  localparam logic [1:0] REQ_NONE  = 2'd0;
  localparam logic [1:0] REQ_FETCH = 2'd1;
  localparam logic [1:0] REQ_DATA  = 2'd2;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Saturating increment for the stall counter.
  function automatic logic [15:0] stall_inc(input logic [15:0] cnt);
    return (cnt == STALL_MAX) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Two-input read-port picker. win = 0 selects req_a (fetch), 1 selects req_b (data).
// RAM_ARB_ROUND_ROBIN_EN: a conflict goes to the input that did not win last time
// (last = 1 means req_b won last). Otherwise req_b has fixed priority.
module ram_arb_pick (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic win
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Round-robin: on conflict the previous loser wins; a lone requester always wins.
  always_comb begin
    win = 1'b0;
    if (req_a && req_b) begin
      win = ~last;
    end else begin
      win = req_b;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: data side wins whenever it asks, including req_a && req_b.
  always_comb begin
    win = 1'b0;
    win = req_b;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM read port between fetch and load/store, forwards data writes to
// the write port and returns registered read data with a valid strobe to the
// requester that issued the read. Optional macro: RAM_ARB_ROUND_ROBIN_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_mwrite,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       stall_cnt
);

  logic [1:0]  rd_owner_q, rd_owner_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        fetch_rd, data_rd, conflict, win, last;
  logic        grant_data_rd, refused;

  assign fetch_rd = if_req;
  assign data_rd  = d_req & ~d_we;
  assign conflict = fetch_rd & data_rd;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // 0 = fetch won the last conflict, 1 = data won it.
  logic last_winner_q, last_winner_d;

  // Remember the conflict winner; non-conflict cycles leave it alone.
  always_comb begin
    last_winner_d = last_winner_q;
    if (conflict) begin
      last_winner_d = win;
    end
  end

  // Last-winner register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= 1'b0;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

  assign last = last_winner_q;
`else
  assign last = 1'b0;
`endif

  ram_arb_pick u_pick (
    .req_a (fetch_rd),
    .req_b (data_rd),
    .last  (last),
    .win   (win)
  );

  assign grant_data_rd = data_rd & win;

  // Grants, RAM port drive and refusal detection; everything is blocked in reset.
  always_comb begin
    if_gnt     = ~reset & fetch_rd & ~grant_data_rd;
    d_gnt      = ~reset & d_req & (d_we | win);
    ram_mwrite = ~reset & d_req & d_we;
    ram_waddr  = d_addr;
    ram_wdata  = d_wdata;
    ram_raddr  = grant_data_rd ? d_addr : if_addr;
    refused    = (if_req & ~if_gnt) | (d_req & ~d_gnt);
  end

  // Next read owner and stall count.
  always_comb begin
    rd_owner_d = REQ_NONE;
    if (if_gnt) begin
      rd_owner_d = REQ_FETCH;
    end else if (d_gnt && !d_we) begin
      rd_owner_d = REQ_DATA;
    end
    stall_cnt_d = refused ? stall_inc(stall_cnt_q) : stall_cnt_q;
  end

  // Read-owner and stall-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q  <= REQ_NONE;
      stall_cnt_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Read data goes to both sides; the owner's valid (masked in reset) qualifies it.
  always_comb begin
    if_rvalid = ~reset & (rd_owner_q == REQ_FETCH);
    d_rvalid  = ~reset & (rd_owner_q == REQ_DATA);
    if_rdata  = ram_rdata;
    d_rdata   = ram_rdata;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural read-before-write RAM and a
// scoreboard queue of expected read returns. Honours RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  typedef struct packed {
    logic [1:0]  owner;
    logic [15:0] data;
  } exp_t;

  logic        clk, reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [7:0]  if_addr;
  logic [15:0] if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata, d_rdata;
  logic [7:0]  ram_raddr, ram_waddr;
  logic        ram_mwrite;
  logic [15:0] ram_wdata, ram_rdata;
  logic [15:0] stall_cnt;

  logic [15:0] mem [256];
  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  ram_arbiter #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .ram_raddr  (ram_raddr),
    .ram_waddr  (ram_waddr),
    .ram_mwrite (ram_mwrite),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    if (a == 16) return 16'hABCD;
    if (a == 5) return 16'h0001;
    return {8'hA5, 8'(a)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
  end

  // Synchronous RAM: registered read of the old contents, write on the same edge.
  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (ram_mwrite) mem[ram_waddr] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] owner, input logic [15:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  // Advance one clock and compare the read return against the scoreboard head.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    check("if_rvalid", 32'(if_rvalid), 32'(e.owner == REQ_FETCH));
    check("d_rvalid", 32'(d_rvalid), 32'(e.owner == REQ_DATA));
    if (e.owner == REQ_FETCH) check("if_rdata", 32'(if_rdata), 32'(e.data));
    if (e.owner == REQ_DATA) check("d_rdata", 32'(d_rdata), 32'(e.data));
  endtask

  task automatic idle();
    if_req  = 1'b0;
    if_addr = 8'h00;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 8'h00;
    d_wdata = 16'h0000;
  endtask

  initial begin
    logic dwin;
    idle();
    // Reset with requests pending: grants and write enable must stay low.
    reset  = 1'b1;
    if_req = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b1;
    #1;
    check("rst_if_gnt", 32'(if_gnt), 32'(1'b0));
    check("rst_d_gnt", 32'(d_gnt), 32'(1'b0));
    check("rst_mwrite", 32'(ram_mwrite), 32'(1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    #1;
    check("rst_stall", 32'(stall_cnt), 32'(16'h0000));
    check("rst_if_rvalid", 32'(if_rvalid), 32'(1'b0));
    check("rst_d_rvalid", 32'(d_rvalid), 32'(1'b0));
    tick();

    // Fetch only.
    if_req  = 1'b1;
    if_addr = 8'h10;
    #1;
    check("fo_if_gnt", 32'(if_gnt), 32'(1'b1));
    check("fo_d_gnt", 32'(d_gnt), 32'(1'b0));
    check("fo_raddr", 32'(ram_raddr), 32'(8'h10));
    check("fo_mwrite", 32'(ram_mwrite), 32'(1'b0));
    push(REQ_FETCH, 16'hABCD);
    tick();

    // Data write alongside a fetch read.
    if_req  = 1'b1;
    if_addr = 8'h21;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h20;
    d_wdata = 16'h1234;
    #1;
    check("wf_if_gnt", 32'(if_gnt), 32'(1'b1));
    check("wf_d_gnt", 32'(d_gnt), 32'(1'b1));
    check("wf_mwrite", 32'(ram_mwrite), 32'(1'b1));
    check("wf_waddr", 32'(ram_waddr), 32'(8'h20));
    check("wf_wdata", 32'(ram_wdata), 32'(16'h1234));
    check("wf_raddr", 32'(ram_raddr), 32'(8'h21));
    push(REQ_FETCH, init_val(8'h21));
    tick();
    idle();
    tick();
    // Data read of the freshly written word.
    d_req  = 1'b1;
    d_addr = 8'h20;
    #1;
    check("dr_d_gnt", 32'(d_gnt), 32'(1'b1));
    check("dr_raddr", 32'(ram_raddr), 32'(8'h20));
    push(REQ_DATA, 16'h1234);
    tick();
    idle();
    check("pre_conf_stall", 32'(stall_cnt), 32'(16'h0000));

    // Four cycles of read conflict with both requests held.
    for (int k = 0; k < 4; k++) begin
      if_req  = 1'b1;
      if_addr = 8'h30;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 8'h40;
      #1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      dwin = (k % 2) == 0;
`else
      dwin = 1'b1;
`endif
      check("cf_d_gnt", 32'(d_gnt), 32'(dwin));
      check("cf_if_gnt", 32'(if_gnt), 32'(!dwin));
      check("cf_raddr", 32'(ram_raddr), 32'(dwin ? 8'h40 : 8'h30));
      push(dwin ? REQ_DATA : REQ_FETCH, init_val(dwin ? 8'h40 : 8'h30));
      tick();
    end
    check("cf_stall", 32'(stall_cnt), 32'(16'd4));
    idle();

    // Same-address write and fetch: old contents first, new contents next.
    if_req  = 1'b1;
    if_addr = 8'h05;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h05;
    d_wdata = 16'h0002;
    #1;
    check("sa_if_gnt", 32'(if_gnt), 32'(1'b1));
    check("sa_d_gnt", 32'(d_gnt), 32'(1'b1));
    push(REQ_FETCH, 16'h0001);
    tick();
    idle();
    if_req  = 1'b1;
    if_addr = 8'h05;
    #1;
    push(REQ_FETCH, 16'h0002);
    tick();
    idle();

    // Reset lands on the cycle after a fetch grant: that return is dropped.
    if_req  = 1'b1;
    if_addr = 8'h10;
    #1;
    check("rf_if_gnt", 32'(if_gnt), 32'(1'b1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rf_if_rvalid", 32'(if_rvalid), 32'(1'b0));
    check("rf_if_gnt_rst", 32'(if_gnt), 32'(1'b0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    #1;
    check("rf_stall", 32'(stall_cnt), 32'(16'h0000));
    check("rf_if_rvalid2", 32'(if_rvalid), 32'(1'b0));
    tick();

    // Saturation: 70000 conflict cycles, one side refused each time.
    if_req  = 1'b1;
    if_addr = 8'h01;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 8'h02;
    for (int i = 1; i <= 70000; i++) begin
      @(posedge clk);
      if (i == 65534) begin
        #1;
        check("sat_fffe", 32'(stall_cnt), 32'(16'hFFFE));
      end
      if (i == 65535) begin
        #1;
        check("sat_ffff", 32'(stall_cnt), 32'(16'hFFFF));
      end
    end
    #1;
    check("sat_hold", 32'(stall_cnt), 32'(16'hFFFF));
    idle();
    tick();
    check("sat_idle", 32'(stall_cnt), 32'(16'hFFFF));
    check("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
